// File: rtl/light_mode_controller.sv
// rtl/light_mode_controller.sv - rear light mode sequencer, blink-rate register and beat prescaler
// Define FLASH_MODE_EN to add the FLASH mode (1 beat on, 3 beats off) to the mode cycle.
module light_mode_controller #(
  parameter int RATE_W       = 4,
  parameter int RATE_DEFAULT = 2,
  parameter int RATE_MIN     = 1,
  parameter int RATE_MAX     = 15,
  parameter int BEAT_DIV     = 1562500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              next,
  input  logic              faster,
  input  logic              slower,
  output logic              rear_light,
  output logic [1:0]        mode,
  output logic [RATE_W-1:0] rate,
  output logic              beat
);

  localparam int PRE_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    ON    = 2'b01,
    BLINK = 2'b10,
    FLASH = 2'b11
  } mode_t;

  mode_t             state_q, state_d;
  logic [PRE_W-1:0]  pre_q;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] phase_q, phase_d;
  logic [RATE_W:0]   phase_inc;
  logic              light_q, light_d;
  logic              next_prev, faster_prev, slower_prev;
  logic              press_next, press_faster, press_slower;
`ifdef FLASH_MODE_EN
  logic [1:0]        flash_q, flash_d;
`endif

  assign press_next   = next & ~next_prev;
  assign press_faster = faster & ~faster_prev;
  assign press_slower = slower & ~slower_prev;
  assign beat         = (pre_q == PRE_W'(BEAT_DIV - 1));
  assign phase_inc    = {1'b0, phase_q} + {{RATE_W{1'b0}}, 1'b1};

  assign rear_light = light_q;
  assign mode       = state_q;
  assign rate       = rate_q;

  // History regs reset high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= OFF;
      pre_q       <= '0;
      rate_q      <= RATE_W'(RATE_DEFAULT);
      phase_q     <= '0;
      light_q     <= 1'b0;
      next_prev   <= 1'b1;
      faster_prev <= 1'b1;
      slower_prev <= 1'b1;
`ifdef FLASH_MODE_EN
      flash_q     <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      pre_q       <= beat ? '0 : pre_q + PRE_W'(1);
      rate_q      <= rate_d;
      phase_q     <= phase_d;
      light_q     <= light_d;
      next_prev   <= next;
      faster_prev <= faster;
      slower_prev <= slower;
`ifdef FLASH_MODE_EN
      flash_q     <= flash_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (press_next) begin
      case (state_q)
        OFF:     state_d = ON;
        ON:      state_d = BLINK;
`ifdef FLASH_MODE_EN
        BLINK:   state_d = FLASH;
`else
        BLINK:   state_d = OFF;
`endif
        default: state_d = OFF;
      endcase
    end
  end

  // A mode change loads entry values and swallows any coincident beat or rate press.
  always_comb begin
    light_d = light_q;
    phase_d = phase_q;
    rate_d  = rate_q;
`ifdef FLASH_MODE_EN
    flash_d = flash_q;
`endif
    if (press_next) begin
      light_d = (state_d != OFF);
      phase_d = '0;
`ifdef FLASH_MODE_EN
      flash_d = 2'd0;
`endif
    end else begin
      case (state_q)
        BLINK: begin
          if (press_faster && !press_slower && rate_q > RATE_W'(RATE_MIN))
            rate_d = rate_q - RATE_W'(1);
          else if (press_slower && !press_faster && rate_q < RATE_W'(RATE_MAX))
            rate_d = rate_q + RATE_W'(1);
          if (beat) begin
            if (phase_inc >= {1'b0, rate_q}) begin
              light_d = ~light_q;
              phase_d = '0;
            end else begin
              phase_d = phase_inc[RATE_W-1:0];
            end
          end
        end
`ifdef FLASH_MODE_EN
        FLASH: begin
          if (beat)
            flash_d = flash_q + 2'd1;
          light_d = (flash_d == 2'd0);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_light_mode_controller.sv
// tb/tb_light_mode_controller.sv - scoreboard bench for light_mode_controller with BEAT_DIV=4
module tb_light_mode_controller;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       next = 1'b0, faster = 1'b0, slower = 1'b0;
  logic       rear_light, beat;
  logic [1:0] mode;
  logic [3:0] rate;

  light_mode_controller #(
    .RATE_W(4), .RATE_DEFAULT(2), .RATE_MIN(1), .RATE_MAX(15), .BEAT_DIV(DIV)
  ) dut (
    .clk(clk), .reset(reset), .next(next), .faster(faster), .slower(slower),
    .rear_light(rear_light), .mode(mode), .rate(rate), .beat(beat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic       light;
    logic [3:0] rate;
    logic       beat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  int m_mode, m_light, m_rate, m_phase, m_fl, m_cnt;
  bit m_np, m_fp, m_sp;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mode_after(input int cur);
    case (cur)
      0: return 1;
      1: return 2;
`ifdef FLASH_MODE_EN
      2: return 3;
`else
      2: return 0;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit n, input bit f, input bit s, input bit r);
    bit pn, pf, ps, bt;
    int old_rate;
    exp_t e;
    if (r) begin
      m_mode = 0; m_light = 0; m_rate = 2; m_phase = 0; m_fl = 0; m_cnt = 0;
      m_np = 1; m_fp = 1; m_sp = 1;
    end else begin
      pn = n && !m_np; pf = f && !m_fp; ps = s && !m_sp;
      bt = (m_cnt == DIV - 1);
      old_rate = m_rate;
      if (pn) begin
        m_mode = mode_after(m_mode);
        m_light = (m_mode != 0) ? 1 : 0;
        m_phase = 0;
        m_fl = 0;
      end else if (m_mode == 2) begin
        if (pf && !ps && m_rate > 1) m_rate--;
        if (ps && !pf && m_rate < 15) m_rate++;
        if (bt) begin
          if (m_phase + 1 >= old_rate) begin
            m_light = 1 - m_light;
            m_phase = 0;
          end else m_phase++;
        end
      end else if (m_mode == 3) begin
        if (bt) m_fl = (m_fl + 1) % 4;
        m_light = (m_fl == 0) ? 1 : 0;
      end
      m_np = n; m_fp = f; m_sp = s;
      m_cnt = (m_cnt + 1) % DIV;
    end
    e.mode = 2'(m_mode);
    e.light = m_light[0];
    e.rate = 4'(m_rate);
    e.beat = (m_cnt == DIV - 1);
    sb.push_back(e);
  endtask

  task automatic cyc(input bit n, input bit f, input bit s, input bit r);
    exp_t e;
    next = n; faster = f; slower = s; reset = r;
    model_step(n, f, s, r);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("mode", int'(mode), int'(e.mode));
      check("rear_light", int'(rear_light), int'(e.light));
      check("rate", int'(rate), int'(e.rate));
      check("beat", int'(beat), int'(e.beat));
`ifndef FLASH_MODE_EN
      check("no_flash_code", int'(mode == 2'b11), 0);
`endif
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic press(input bit n, input bit f, input bit s);
    cyc(n, f, s, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 4 && m_mode != target; i++) press(1, 0, 0);
    check("goto_mode", int'(mode), target);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
    check("rst_mode", int'(mode), 0);
    check("rst_light", int'(rear_light), 0);
    check("rst_rate", int'(rate), 2);
    check("rst_beat", int'(beat), 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
    check("held_next_no_press", int'(mode), 0);
    idle(1);

    press(1, 0, 0); check("cycle_on", int'(mode), 1); check("cycle_on_light", int'(rear_light), 1);
    press(1, 0, 0); check("cycle_blink", int'(mode), 2);
`ifdef FLASH_MODE_EN
    press(1, 0, 0); check("cycle_flash", int'(mode), 3);
`endif
    press(1, 0, 0); check("cycle_off", int'(mode), 0); check("cycle_off_light", int'(rear_light), 0);

    goto_mode(2);
    idle(24);
    press(0, 1, 0); check("faster_rate", int'(rate), 1);
    idle(13);
    press(0, 1, 0); idle(2);
    press(0, 1, 0); check("rate_min_sat", int'(rate), 1);
    idle(9);

    for (int i = 0; i < 14; i++) press(0, 0, 1);
    check("rate_max_sat", int'(rate), 15);
    for (int i = 0; i < 4; i++) press(0, 1, 0);
    check("rate_after_faster", int'(rate), 11);
    press(0, 1, 1); check("both_dropped", int'(rate), 11);
    idle(7);

    goto_mode(1);
    press(0, 1, 0); check("faster_in_on", int'(rate), 11);
    press(0, 0, 1); check("slower_in_on", int'(rate), 11);

    goto_mode(2);
    for (int i = 0; i < 9; i++) press(0, 1, 0);
    check("rate_two", int'(rate), 2);
    press(1, 0, 1);
`ifdef FLASH_MODE_EN
    check("next_wins_mode", int'(mode), 3);
`else
    check("next_wins_mode", int'(mode), 0);
`endif
    check("next_wins_rate", int'(rate), 2);
    idle(35);

    goto_mode(2);
    for (int i = 0; i < 3; i++) press(0, 0, 1);
    check("rate_five", int'(rate), 5);
    idle(11);
    cyc(0, 0, 0, 1);
    check("midrst_mode", int'(mode), 0);
    check("midrst_rate", int'(rate), 2);
    check("midrst_light", int'(rear_light), 0);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
